// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : icache_dm
//  Purpose  : Direct-mapped, read-only instruction cache sitting between the
//             PC and the IF pipeline register. Hits return the instruction in
//             the same cycle; misses run a single-line fill from memory over a
//             req/ready handshake while ic_stall holds the front end.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_WIDTH  byte address width of pc and mem_addr (default 32)
//    INDEX_BITS  log2 of the line count (default 4 -> 16 lines)
//  Line geometry is fixed at 4 words x 32 bits = 128 bits.
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock, all state changes on the rising edge
//    reset      in   synchronous, active-high reset
//    pc         in   fetch byte address (bits [1:0] ignored)
//    rd_en      in   a fetch is requested this cycle
//    inv        in   invalidate every line
//    instr      out  fetched instruction, valid when rd_en && !ic_stall
//    ic_stall   out  the fetch cannot complete this cycle
//    mem_req    out  registered line fill request
//    mem_addr   out  registered, line-aligned fill address
//    mem_ready  in   mem_rdata holds the requested line this cycle
//    mem_rdata  in   fill line, word k at bits [32k+31:32k]
// ============================================================================
module icache_dm #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  rd_en,
  input  logic                  inv,
  output logic [31:0]           instr,
  output logic                  ic_stall,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [127:0]          mem_rdata
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - 4 - INDEX_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t state;

  // Lookup address split
  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;

  assign offset = pc[3:2];
  assign index  = pc[3+INDEX_BITS:4];
  assign tag    = pc[ADDR_WIDTH-1:4+INDEX_BITS];

  // The latched fill address doubles as the fill index/tag source, so no
  // separate line-address register is kept.
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;

  assign fill_index = mem_addr[3+INDEX_BITS:4];
  assign fill_tag   = mem_addr[ADDR_WIDTH-1:4+INDEX_BITS];

  // Byte-offset bits of pc and the always-zero low bits of mem_addr carry no
  // information for the cache.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, pc[1:0], mem_addr[3:0]};

  // Storage: valid bits need reset; tag/data arrays do not.
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_array  [LINES];
  logic [127:0]        data_array [LINES];

  logic        hit;
  logic        miss_launch;
  logic        fill_done;
  logic [31:0] hit_word;

  assign hit         = valid[index] && (tag_array[index] == tag);
  assign hit_word    = data_array[index][{offset, 5'b0} +: 32];
  assign miss_launch = (state == IDLE) && rd_en && !hit;
  // A reset in the same cycle as mem_ready aborts the fill with no write.
  assign fill_done   = (state == FILL) && mem_ready && !reset;

  // Combinational outputs, both forced quiet while reset is asserted.
  always_comb begin
    instr    = 32'h0;
    ic_stall = 1'b0;
    if (!reset) begin
      instr    = hit ? hit_word : 32'h0;
      ic_stall = (state == FILL) || miss_launch;
    end
  end

  // Control FSM with registered mem_req/mem_addr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      valid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_launch) begin
            state    <= FILL;
            mem_req  <= 1'b1;
            mem_addr <= {tag, index, 4'b0000};
          end
        end
        FILL: begin
          if (mem_ready) begin
            state             <= IDLE;
            mem_req           <= 1'b0;
            valid[fill_index] <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
      // Flush wins over a coincident fill: the later assignment overrides
      // the valid bit set above, so the freshly filled line is discarded.
      if (inv) begin
        valid <= '0;
      end
    end
  end

  // Tag/data array write port; written only when a fill completes.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_array[fill_index]  <= fill_tag;
      data_array[fill_index] <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_dm
//  Purpose  : Self-checking bench for icache_dm. A line-level model of the
//             cache (valid/tag/data per line plus an outstanding-fill flag)
//             predicts every output on each falling edge; directed steps add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_dm;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  pc = 32'h0;
  logic         rd_en = 1'b0;
  logic         inv = 1'b0;
  logic [31:0]  instr;
  logic         ic_stall;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready = 1'b0;
  logic [127:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  icache_dm #(.ADDR_WIDTH(32), .INDEX_BITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .rd_en     (rd_en),
    .inv       (inv),
    .instr     (instr),
    .ic_stall  (ic_stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Model: 16 lines, line number = byte address / 16, index = line % 16,
  // tag = line / 16. m_fill marks an outstanding fill of line m_line.
  // -------------------------------------------------------------------------
  bit [15:0]   m_valid = '0;
  int unsigned m_tag  [16];
  bit [127:0]  m_data [16];
  bit          m_fill = 1'b0;
  int unsigned m_line = 0;

  function automatic bit m_hit(input logic [31:0] a);
    int unsigned ln;
    ln = a / 16;
    return m_valid[ln % 16] && (m_tag[ln % 16] == ln / 16);
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    int unsigned ln;
    ln = a / 16;
    return 32'(m_data[ln % 16] >> (32 * ((a / 4) % 4)));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= '0;
      m_fill  <= 1'b0;
      m_line  <= 0;
    end else begin
      if (!m_fill) begin
        if (rd_en && !m_hit(pc)) begin
          m_fill <= 1'b1;
          m_line <= pc / 16;
        end
      end else if (mem_ready) begin
        m_tag[m_line % 16]   <= m_line / 16;
        m_data[m_line % 16]  <= mem_rdata;
        m_valid[m_line % 16] <= 1'b1;
        m_fill               <= 1'b0;
      end
      if (inv) m_valid <= '0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Model-driven comparison every cycle once the first reset edge has passed.
  always @(negedge clk) begin
    if (started) begin
      logic        h;
      logic        e_stall;
      logic [31:0] e_instr;
      h       = m_hit(pc);
      e_stall = !reset && (m_fill || (rd_en && !h));
      e_instr = (!reset && h) ? m_word(pc) : 32'h0;
      check("model_ic_stall", {31'b0, ic_stall}, {31'b0, e_stall});
      check("model_mem_req",  {31'b0, mem_req},  {31'b0, m_fill});
      check("model_mem_addr", mem_addr, m_line * 16);
      if (rd_en && !e_stall) check("model_instr", instr, e_instr);
      else if (reset)        check("model_instr_rst", instr, 32'h0);
    end
  end

  // One cycle: drive inputs just after the rising edge, return at the
  // following falling edge so the caller can sample settled outputs.
  task automatic tick(input logic rst, input logic [31:0] a, input logic rd,
                      input logic iv, input logic rdy, input logic [127:0] line);
    @(posedge clk);
    #1;
    reset     = rst;
    pc        = a;
    rd_en     = rd;
    inv       = iv;
    mem_ready = rdy;
    mem_rdata = line;
    @(negedge clk);
  endtask

  localparam logic [127:0] L100 = {32'h33, 32'h22, 32'h11, 32'h00};
  localparam logic [127:0] L200 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] L300 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [127:0] L410 = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
  localparam logic [127:0] LBAD = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};

  initial begin
    // Reset, with a fetch request pending to show outputs stay quiet.
    tick(1, 32'h100, 1, 0, 0, '0);
    started = 1'b1;
    tick(1, 32'h100, 1, 0, 0, '0);
    check("rst_stall", {31'b0, ic_stall}, 32'h0);
    check("rst_req",   {31'b0, mem_req},  32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_addr",  mem_addr, 32'h0);

    // Cold miss at 0x100, ready in the 3rd FILL cycle.
    tick(0, 32'h100, 1, 0, 0, '0);
    check("miss_stall", {31'b0, ic_stall}, 32'h1);
    check("miss_req0",  {31'b0, mem_req},  32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 32'h100, 1, 0, (k == 2), L100);
      check("fill_stall", {31'b0, ic_stall}, 32'h1);
      check("fill_req",   {31'b0, mem_req},  32'h1);
      check("fill_addr",  mem_addr, 32'h100);
    end
    tick(0, 32'h100, 1, 0, 0, '0);
    check("hit0_stall", {31'b0, ic_stall}, 32'h0);
    check("hit0_instr", instr, 32'h00);
    check("hit0_req",   {31'b0, mem_req},  32'h0);

    // Sequential words of the resident line.
    tick(0, 32'h104, 1, 0, 0, '0);
    check("hit1_instr", instr, 32'h11);
    tick(0, 32'h108, 1, 0, 0, '0);
    check("hit2_instr", instr, 32'h22);
    tick(0, 32'h10C, 1, 0, 0, '0);
    check("hit3_instr", instr, 32'h33);
    check("hit3_req",   {31'b0, mem_req}, 32'h0);

    // Conflict: 0x200 maps to index 0 with a different tag.
    tick(0, 32'h200, 1, 0, 0, '0);
    check("conf_stall", {31'b0, ic_stall}, 32'h1);
    tick(0, 32'h200, 1, 0, 1, L200);
    check("conf_addr", mem_addr, 32'h200);
    tick(0, 32'h204, 1, 0, 0, '0);
    check("conf_instr", instr, 32'hA1);
    tick(0, 32'h100, 1, 0, 0, '0);
    check("evict_stall", {31'b0, ic_stall}, 32'h1);
    tick(0, 32'h100, 1, 0, 1, L100);
    tick(0, 32'h108, 1, 0, 0, '0);
    check("refill_instr", instr, 32'h22);

    // Flush with 0x100 resident, then the next fetch must miss.
    tick(0, 32'h100, 0, 1, 0, '0);
    tick(0, 32'h100, 1, 0, 0, '0);
    check("inv_miss", {31'b0, ic_stall}, 32'h1);
    // inv without mem_ready keeps the fill running; inv with ready discards.
    tick(0, 32'h100, 1, 1, 0, '0);
    check("inv_hold_req", {31'b0, mem_req}, 32'h1);
    tick(0, 32'h100, 1, 1, 1, L100);
    tick(0, 32'h100, 1, 0, 0, '0);
    check("inv_fill_remiss", {31'b0, ic_stall}, 32'h1);
    tick(0, 32'h100, 1, 0, 1, L100);
    check("inv_rereq", {31'b0, mem_req}, 32'h1);
    tick(0, 32'h10C, 1, 0, 0, '0);
    check("inv_refill", instr, 32'h33);

    // Redirect during a fill: 0x300 is installed, the new pc then misses.
    tick(0, 32'h300, 1, 0, 0, '0);
    tick(0, 32'h410, 1, 0, 1, L300);
    tick(0, 32'h410, 1, 0, 0, '0);
    check("redir_miss", {31'b0, ic_stall}, 32'h1);
    tick(0, 32'h410, 1, 0, 1, L410);
    check("redir_addr", mem_addr, 32'h410);
    tick(0, 32'h308, 1, 0, 0, '0);
    check("redir_old_hit", instr, 32'hB2);

    // Reset in the 2nd FILL cycle, then a stray mem_ready.
    tick(0, 32'h520, 1, 0, 0, '0);
    tick(0, 32'h520, 1, 0, 0, '0);
    tick(1, 32'h520, 1, 0, 0, '0);
    check("rstfill_stall", {31'b0, ic_stall}, 32'h0);
    tick(0, 32'h520, 0, 0, 1, LBAD);
    check("rstfill_req", {31'b0, mem_req}, 32'h0);
    tick(0, 32'h520, 0, 0, 0, '0);
    check("rstfill_idle", {31'b0, mem_req}, 32'h0);
    tick(0, 32'h308, 1, 0, 0, '0);
    check("rstfill_flushed", {31'b0, ic_stall}, 32'h1);
    tick(0, 32'h308, 1, 0, 1, L300);
    tick(0, 32'h520, 1, 0, 0, '0);
    check("rstfill_nowrite", {31'b0, ic_stall}, 32'h1);
    tick(0, 32'h520, 1, 0, 1, L410);
    tick(0, 32'h524, 1, 0, 0, '0);
    check("rstfill_new", instr, 32'hC1);

    // rd_en low on a missing pc, plus mem_ready in IDLE.
    tick(0, 32'h700, 0, 0, 0, '0);
    check("nord_stall", {31'b0, ic_stall}, 32'h0);
    check("nord_req",   {31'b0, mem_req},  32'h0);
    tick(0, 32'h700, 0, 0, 1, LBAD);
    tick(0, 32'h700, 0, 0, 0, '0);
    check("idle_rdy_req", {31'b0, mem_req}, 32'h0);
    tick(0, 32'h524, 1, 0, 0, '0);
    check("idle_rdy_keep", instr, 32'hC1);
    tick(0, 32'h700, 1, 0, 0, '0);
    check("idle_rdy_miss", {31'b0, ic_stall}, 32'h1);
    tick(0, 32'h700, 0, 0, 1, L200);
    tick(0, 32'h700, 0, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
